hsp_fifo_param: RTL
===================

Name: hsp_fifo_param

Overview:
Parametrised FIFO for high-scoring-pair (HSP) records. Each record carries four fields: subject offset s, query offset q, length l and score.
Sits between the ungapped-extension stage and the host/PCIe readout path. Adds valid/ready handshakes, a configurable depth and field width, a zero-length filter, an almost-full flag and a synchronous flush.
Output is first-word-fall-through: the head record is visible whenever out_valid is high.

Parameters:
FIELD_W, 8, width of each field (s, q, l, score)
DEPTH, 16, record entries; must be a power of two and at least 2
AW, $clog2(DEPTH), pointer width (derived; not overridden)
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of pointers and count
in_valid  in  1  upstream record valid
in_ready  out  1  FIFO can accept a record
in_s  in  FIELD_W  subject offset
in_q  in  FIELD_W  query offset
in_l  in  FIELD_W  HSP length; 0 means no hit
in_score  in  FIELD_W  HSP score
out_valid  out  1  head record present
out_ready  in  1  downstream consumes head
out_s  out  FIELD_W  head subject offset
out_q  out  FIELD_W  head query offset
out_l  out  FIELD_W  head length
out_score  out  FIELD_W  head score
count  out  AW+1  stored records, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH

Behaviour:
- Reset (asynchronous, rst=1): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs after reset: empty=1, full=0, almost_full=0 (AF_THRESH>0), out_valid=0, in_ready=1, all out_* fields = 0.
  - Memory contents are not reset.
- in_ready = !full (combinational from registered count).
- Accept: the input is accepted when in_valid && in_ready.
- Push: a push occurs when the input is accepted and in_l != 0.
  - On push, all four fields are written to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
- Zero-length filter: an accepted record with in_l == 0 is consumed (the handshake completes) but is not stored. Pointers and count are unchanged.
- Pop: out_valid = !empty. A pop occurs when out_valid && out_ready; rd_ptr then increments modulo DEPTH.
- Output fields: out_* = mem[rd_ptr] (asynchronous read) while out_valid=1, and are forced to 0 while out_valid=0.
- Latency: a record pushed on edge N is visible at the output (out_valid=1) after edge N; minimum 1 cycle from in to out.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, with both pointers advancing
  - neither: hold
- Full: in_ready=0, so no push occurs even if a pop happens in the same cycle. in_ready rises on the cycle after the pop.
- Empty: out_valid=0, so no pop can occur. A push into an empty FIFO is not bypassed to the output in the same cycle.
- Wrap-around: pointers are AW bits wide and wrap naturally. Full and empty are distinguished by count, never by pointer equality.
- Flush (synchronous): wr_ptr=0, rd_ptr=0, count=0. Flush has priority over a same-cycle push or pop; that push is lost and that pop has no effect.
- Reset mid-operation: asserting rst immediately returns all state to reset values, regardless of handshake state.
- Upstream rule: upstream must hold in_* stable while in_valid=1 and in_ready=0. The FIFO does not check this.

Optional Feature:
Macro: HSP_FIFO_LOSSY_EN.
- Defined:
  - in_ready is tied to 1.
  - A record with in_l != 0 arriving while full=1 is discarded, and the stored contents are unchanged.
  - An extra output port drop_cnt [15:0] increments on each such discard and saturates at 16'hFFFF.
  - drop_cnt is cleared by rst and by flush.
  - A discard in the same cycle as a pop is still a discard: full is evaluated before the pop.
- Undefined:
  - Back-pressure mode: in_ready = !full.
  - No drop_cnt port exists.

Test Plan (FIELD_W=8, DEPTH=4, AF_THRESH=2):
1. Reset, then push (s,q,l,score)=(01,02,03,04).
   - Next cycle: out_valid=1, out_*=01,02,03,04, count=1.
   - Pop: out_valid=0, out_*=00.
2. Push 5 records with l=1..5 while out_ready=0.
   - First 4 stored; full=1 and in_ready=0 from the 4th push.
   - 5th held by upstream until one pop, then accepted.
   - Popped order of l: 1,2,3,4,5.
3. Push records with l=0,7,0,9.
   - All handshakes complete; only l=7 and l=9 stored; count=2; almost_full=1.
4. Continuous push and pop with out_ready=1 for 10 cycles, l=1..10.
   - count stays 1 after the first cycle; pointers wrap twice; outputs l=1..10 in order.
5. Hold count=3, then assert flush with a simultaneous push of l=5.
   - Next cycle: count=0, empty=1, out_valid=0; l=5 not stored.
   - Separately, rst asserted mid-stream: outputs zero immediately.
6. With HSP_FIFO_LOSSY_EN defined: fill 4 records, then push 3 more with l!=0 and out_ready=0.
   - drop_cnt=3, in_ready stays 1, stored contents unchanged.
   - flush: drop_cnt=0.

Source files
------------

// File: rtl/hsp_fifo_param_if.sv
// hsp_fifo_param_if: valid/ready record bus around the HSP FIFO.
//   in_*  : upstream record channel (in_valid/in_ready plus s, q, l, score)
//   out_* : downstream record channel (out_valid/out_ready plus s, q, l, score)
//   slave  modport: the FIFO side (accepts in_*, drives out_* and in_ready)
//   master modport: the surrounding logic (drives in_* and out_ready)
interface hsp_fifo_param_if #(
  parameter int FIELD_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [FIELD_W-1:0] in_s;
  logic [FIELD_W-1:0] in_q;
  logic [FIELD_W-1:0] in_l;
  logic [FIELD_W-1:0] in_score;
  logic               out_valid;
  logic               out_ready;
  logic [FIELD_W-1:0] out_s;
  logic [FIELD_W-1:0] out_q;
  logic [FIELD_W-1:0] out_l;
  logic [FIELD_W-1:0] out_score;

  modport slave (
    input  in_valid, in_s, in_q, in_l, in_score, out_ready,
    output in_ready, out_valid, out_s, out_q, out_l, out_score
  );

  modport master (
    output in_valid, in_s, in_q, in_l, in_score, out_ready,
    input  in_ready, out_valid, out_s, out_q, out_l, out_score
  );
endinterface

// File: rtl/hsp_fifo_param.sv
// hsp_fifo_param: first-word-fall-through FIFO for HSP records (s, q, l, score).
//   clk, rst     : clock, asynchronous active-high reset
//   flush        : synchronous clear of pointers/count (wins over push/pop)
//   bus          : hsp_fifo_param_if.slave record channels
//   count        : stored records 0..DEPTH
//   empty/full   : count == 0 / count == DEPTH
//   almost_full  : count >= AF_THRESH
// Records with l == 0 complete the handshake but are not stored.
// Optional macro HSP_FIFO_LOSSY_EN: in_ready tied high, records arriving
// while full are discarded and counted on drop_cnt (saturating, cleared by
// rst and flush).
module hsp_fifo_param #(
  parameter int FIELD_W   = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  hsp_fifo_param_if.slave          bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
`ifdef HSP_FIFO_LOSSY_EN
  output logic                     almost_full,
  output logic [15:0]              drop_cnt
`else
  output logic                     almost_full
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_THRESH[AW:0];

  logic [4*FIELD_W-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q,  count_d;
  logic                 push, pop, accept;
  logic [4*FIELD_W-1:0] head;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign count       = count_q;

`ifdef HSP_FIFO_LOSSY_EN
  logic [15:0] drop_q, drop_d;
  logic        drop;
  assign bus.in_ready = 1'b1;
  assign accept       = bus.in_valid;
  // Full is sampled from the registered count, so a same-cycle pop does not
  // rescue an incoming record.
  assign drop         = accept && (bus.in_l != '0) && full;
  assign drop_cnt     = drop_q;
`else
  assign bus.in_ready = !full;
  assign accept       = bus.in_valid && !full;
`endif

  assign push = accept && (bus.in_l != '0) && !full;
  assign pop  = bus.out_valid && bus.out_ready;

  assign bus.out_valid = !empty;
  assign head          = mem[rd_ptr_q];
  assign bus.out_s     = bus.out_valid ? head[4*FIELD_W-1:3*FIELD_W] : '0;
  assign bus.out_q     = bus.out_valid ? head[3*FIELD_W-1:2*FIELD_W] : '0;
  assign bus.out_l     = bus.out_valid ? head[2*FIELD_W-1:FIELD_W]   : '0;
  assign bus.out_score = bus.out_valid ? head[FIELD_W-1:0]           : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

`ifdef HSP_FIFO_LOSSY_EN
  always_comb begin
    drop_d = drop_q;
    if (flush)                        drop_d = '0;
    else if (drop && (drop_q != '1))  drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr_q] <= {bus.in_s, bus.in_q, bus.in_l, bus.in_score};
  end
endmodule
